// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed on-chip memory.
// Write path: four-state FSM that accepts AW and W in either order or together,
// commits the strobed bytes on the edge entering W_RESP and answers on B.
// Read path: three-state FSM that snapshots the addressed word on the AR
// handshake edge and presents it READ_LATENCY cycles later on R.
// All state, including the memory array, is cleared by the asynchronous reset.
module axi_lite_slave_mem #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    // write response channel
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    // read data channel
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int OFFSET_BITS = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Counter preload so that R_RESP is entered READ_LATENCY-1 edges after
    // the handshake edge (the first edge in R_WAIT already counts).
    localparam int LAT_LOAD    = (READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0;

    localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA    = {(DATA_WIDTH / 32){32'hDEAD_DEAD}};
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Word index of a byte address; low offset bits are simply dropped.
    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr >> OFFSET_BITS;
    endfunction

    // The full (untruncated) index must fall inside the array, so an index
    // such as MEM_DEPTH never aliases onto word 0.
    function automatic logic index_in_range(input logic [ADDR_WIDTH-1:0] idx);
        return ({1'b0, idx} < DEPTH_LIMIT);
    endfunction

    // Byte-lane merge: lanes with a set strobe take the new data.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_word[k*8 +: 8];
            end else begin
                res[k*8 +: 8] = old_word[k*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    logic                  ready_en_r;

    w_state_t              w_state_r;
    w_state_t              w_state_next_s;
    logic [ADDR_WIDTH-1:0] awaddr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_WIDTH-1:0] wstrb_r;
    logic [1:0]            bresp_r;

    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  commit_s;
    logic [ADDR_WIDTH-1:0] commit_addr_s;
    logic [DATA_WIDTH-1:0] commit_data_s;
    logic [STRB_WIDTH-1:0] commit_strb_s;
    logic [ADDR_WIDTH-1:0] commit_idx_full_s;
    logic [IDX_WIDTH-1:0]  commit_idx_s;
    logic                  commit_ok_s;

    r_state_t              r_state_r;
    r_state_t              r_state_next_s;
    logic [1:0]            lat_cnt_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            rresp_r;

    logic                  ar_hs_s;
    logic [ADDR_WIDTH-1:0] ar_idx_full_s;
    logic [IDX_WIDTH-1:0]  ar_idx_s;
    logic                  ar_ok_s;

    // ------------------------------------------------------------------
    // Output decodes (all from registered state)
    // ------------------------------------------------------------------
    assign AWREADY = ready_en_r & ((w_state_r == W_IDLE) | (w_state_r == W_DATA));
    assign WREADY  = ready_en_r & ((w_state_r == W_IDLE) | (w_state_r == W_ADDR));
    assign BVALID  = (w_state_r == W_RESP);
    assign BRESP   = bresp_r;

    assign ARREADY = ready_en_r & (r_state_r == R_IDLE);
    assign RVALID  = (r_state_r == R_RESP);
    assign RDATA   = rdata_r;
    assign RRESP   = rresp_r;

    assign aw_hs_s = AWVALID & AWREADY;
    assign w_hs_s  = WVALID  & WREADY;
    assign ar_hs_s = ARVALID & ARREADY;

    assign commit_idx_full_s = word_index(commit_addr_s);
    assign commit_idx_s      = commit_idx_full_s[IDX_WIDTH-1:0];
    assign commit_ok_s       = index_in_range(commit_idx_full_s);

    assign ar_idx_full_s = word_index(ARADDR);
    assign ar_idx_s      = ar_idx_full_s[IDX_WIDTH-1:0];
    assign ar_ok_s       = index_in_range(ar_idx_full_s);

    // Holds the READY outputs low during reset and releases them on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------

    // Write FSM next state and selection of the address/data being committed.
    always_comb begin
        w_state_next_s = w_state_r;
        commit_s       = 1'b0;
        commit_addr_s  = awaddr_r;
        commit_data_s  = wdata_r;
        commit_strb_s  = wstrb_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    w_state_next_s = W_RESP;
                    commit_s       = 1'b1;
                    commit_addr_s  = AWADDR;
                    commit_data_s  = WDATA;
                    commit_strb_s  = WSTRB;
                end else if (aw_hs_s) begin
                    w_state_next_s = W_ADDR;
                end else if (w_hs_s) begin
                    w_state_next_s = W_DATA;
                end else begin
                    w_state_next_s = W_IDLE;
                end
            end
            W_ADDR: begin
                if (w_hs_s) begin
                    w_state_next_s = W_RESP;
                    commit_s       = 1'b1;
                    commit_data_s  = WDATA;
                    commit_strb_s  = WSTRB;
                end else begin
                    w_state_next_s = W_ADDR;
                end
            end
            W_DATA: begin
                if (aw_hs_s) begin
                    w_state_next_s = W_RESP;
                    commit_s       = 1'b1;
                    commit_addr_s  = AWADDR;
                end else begin
                    w_state_next_s = W_DATA;
                end
            end
            W_RESP: begin
                if (BVALID && BREADY) begin
                    w_state_next_s = W_IDLE;
                end else begin
                    w_state_next_s = W_RESP;
                end
            end
            default: begin
                w_state_next_s = W_IDLE;
            end
        endcase
    end

    // Write FSM state, captured AW/W beats and the registered write response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            awaddr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= {DATA_WIDTH{1'b0}};
            wstrb_r   <= {STRB_WIDTH{1'b0}};
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_next_s;
            if (aw_hs_s) begin
                awaddr_r <= AWADDR;
            end
            if (w_hs_s) begin
                wdata_r <= WDATA;
                wstrb_r <= WSTRB;
            end
            if (commit_s) begin
                bresp_r <= commit_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Memory array: cleared by reset, updated only by an in-range commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (commit_s && commit_ok_s) begin
            mem_r[commit_idx_s] <= merge_bytes(mem_r[commit_idx_s], commit_data_s, commit_strb_s);
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Read FSM next state; latency 1 skips the wait state entirely.
    always_comb begin
        r_state_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_next_s = (READ_LATENCY <= 1) ? R_RESP : R_WAIT;
                end else begin
                    r_state_next_s = R_IDLE;
                end
            end
            R_WAIT: begin
                if (lat_cnt_r == 2'd0) begin
                    r_state_next_s = R_RESP;
                end else begin
                    r_state_next_s = R_WAIT;
                end
            end
            R_RESP: begin
                if (RVALID && RREADY) begin
                    r_state_next_s = R_IDLE;
                end else begin
                    r_state_next_s = R_RESP;
                end
            end
            default: begin
                r_state_next_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state, latency counter and the word snapshot taken at the AR
    // handshake edge (a write committing on that same edge is not yet visible).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            lat_cnt_r <= 2'd0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_next_s;
            if (ar_hs_s) begin
                lat_cnt_r <= 2'(LAT_LOAD);
                rdata_r   <= ar_ok_s ? mem_r[ar_idx_s] : ERR_DATA;
                rresp_r   <= ar_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else if ((r_state_r == R_WAIT) && (lat_cnt_r != 2'd0)) begin
                lat_cnt_r <= lat_cnt_r - 2'd1;
            end
        end
    end

endmodule
